// File: rtl/writeback_unit.sv
// Writeback stage: classifies retiring instructions into scalar/vector register-file writes
// and buffers them in a small FIFO so the register files can back-pressure the pipeline.
module writeback_unit #(
    parameter int LANES        = 4,
    parameter int LANE_W       = 16,
    parameter int SIDX_W       = 4,
    parameter int VIDX_W       = 6,
    parameter int DEPTH        = 4,
    parameter int OPCODE_WIDTH = 8
) (
    input  logic                      I_CLOCK,
    input  logic                      I_RESET,
    input  logic                      I_LOCK,
    input  logic                      I_Valid,
    output logic                      O_Ready,
    input  logic [OPCODE_WIDTH-1:0]   I_Opcode,
    input  logic [SIDX_W-1:0]         I_DestRegIdx,
    input  logic [VIDX_W-1:0]         I_DestRegIdxV,
    input  logic [$clog2(LANES)-1:0]  I_DestLane,
    input  logic [LANE_W-1:0]         I_ALUOut,
    input  logic [LANE_W-1:0]         I_MemOut,
    input  logic [LANES*LANE_W-1:0]   I_ALUOutV,
    input  logic                      I_FetchStall,
    input  logic                      I_DepStall,
    input  logic                      I_RFReady,
    output logic                      O_WriteBackEnable,
    output logic [SIDX_W-1:0]         O_WriteBackRegIdx,
    output logic [LANE_W-1:0]         O_WriteBackData,
    output logic                      O_WriteBackEnableV,
    output logic [VIDX_W-1:0]         O_WriteBackRegIdxV,
    output logic [LANES-1:0]          O_WriteBackLaneMaskV,
    output logic [LANES*LANE_W-1:0]   O_WriteBackDataV,
    output logic [OPCODE_WIDTH-1:0]   O_Opcode,
    output logic                      O_FetchStall,
    output logic                      O_DepStall,
    output logic [$clog2(DEPTH):0]    O_Count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int VW = LANES * LANE_W;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [OPCODE_WIDTH-1:0] OP_ADD_D     = OPCODE_WIDTH'(8'h01);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI_D    = OPCODE_WIDTH'(8'h02);
    localparam logic [OPCODE_WIDTH-1:0] OP_AND_D     = OPCODE_WIDTH'(8'h03);
    localparam logic [OPCODE_WIDTH-1:0] OP_ANDI_D    = OPCODE_WIDTH'(8'h04);
    localparam logic [OPCODE_WIDTH-1:0] OP_MOV       = OPCODE_WIDTH'(8'h05);
    localparam logic [OPCODE_WIDTH-1:0] OP_MOVI_D    = OPCODE_WIDTH'(8'h06);
    localparam logic [OPCODE_WIDTH-1:0] OP_JSR       = OPCODE_WIDTH'(8'h07);
    localparam logic [OPCODE_WIDTH-1:0] OP_JSRR      = OPCODE_WIDTH'(8'h08);
    localparam logic [OPCODE_WIDTH-1:0] OP_LDW       = OPCODE_WIDTH'(8'h09);
    localparam logic [OPCODE_WIDTH-1:0] OP_VADD      = OPCODE_WIDTH'(8'h10);
    localparam logic [OPCODE_WIDTH-1:0] OP_VMOV      = OPCODE_WIDTH'(8'h11);
    localparam logic [OPCODE_WIDTH-1:0] OP_VCOMPMOV  = OPCODE_WIDTH'(8'h12);
    localparam logic [OPCODE_WIDTH-1:0] OP_VCOMPMOVI = OPCODE_WIDTH'(8'h13);

    logic [OPCODE_WIDTH-1:0] r_op    [DEPTH];
    logic                    r_sen   [DEPTH];
    logic [SIDX_W-1:0]       r_sidx  [DEPTH];
    logic [LANE_W-1:0]       r_sdata [DEPTH];
    logic                    r_ven   [DEPTH];
    logic [VIDX_W-1:0]       r_vidx  [DEPTH];
    logic [LANES-1:0]        r_vmask [DEPTH];
    logic [VW-1:0]           r_vdata [DEPTH];

    logic [PW-1:0] r_wr, r_rd;
    logic [CW-1:0] r_count;
    logic          r_fetch_stall_p1, r_dep_stall_p1;

    logic              w_sen, w_ven, w_space, w_accept, w_push, w_pop;
    logic [SIDX_W-1:0] w_sidx;
    logic [LANE_W-1:0] w_sdata;
    logic [VIDX_W-1:0] w_vidx;
    logic [LANES-1:0]  w_vmask;
    logic [VW-1:0]     w_vdata;

    // Decode the entry an accepted instruction would enqueue; unused fields stay zero
    always_comb begin
        w_sen   = 1'b0;
        w_sidx  = '0;
        w_sdata = '0;
        w_ven   = 1'b0;
        w_vidx  = '0;
        w_vmask = '0;
        w_vdata = '0;
        case (I_Opcode)
            OP_ADD_D, OP_ADDI_D, OP_AND_D, OP_ANDI_D,
            OP_MOV, OP_MOVI_D, OP_JSR, OP_JSRR: begin
                w_sen   = 1'b1;
                w_sidx  = I_DestRegIdx;
                w_sdata = I_ALUOut;
            end
            OP_LDW: begin
                w_sen   = 1'b1;
                w_sidx  = I_DestRegIdx;
                w_sdata = I_MemOut;
            end
            OP_VADD, OP_VMOV: begin
                w_ven   = 1'b1;
                w_vidx  = I_DestRegIdxV;
                w_vmask = '1;
                w_vdata = I_ALUOutV;
            end
            OP_VCOMPMOV, OP_VCOMPMOVI: begin
                w_sen   = 1'b1;
                w_sidx  = I_DestRegIdx;
                w_sdata = I_ALUOut;
                w_ven   = 1'b1;
                w_vidx  = I_DestRegIdxV;
                w_vmask = LANES'(1) << I_DestLane;
                w_vdata = {LANES{I_ALUOut}};
            end
            default: ;
        endcase
    end

    assign w_space  = (r_count < FULL);
    assign w_accept = I_LOCK & I_Valid & w_space & ~I_FetchStall & ~I_DepStall & ~I_RESET;
    assign w_push   = w_accept & (w_sen | w_ven);
    assign w_pop    = I_LOCK & I_RFReady & (r_count != '0) & ~I_RESET;

    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) begin
            r_wr             <= '0;
            r_rd             <= '0;
            r_count          <= '0;
            r_fetch_stall_p1 <= 1'b0;
            r_dep_stall_p1   <= 1'b0;
        end else begin
            r_fetch_stall_p1 <= I_FetchStall;
            r_dep_stall_p1   <= I_DepStall;
            if (w_push) r_wr <= r_wr + PW'(1);
            if (w_pop)  r_rd <= r_rd + PW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
        end
    end

    // Entry storage carries no reset: outputs are masked whenever nothing retires
    always_ff @(posedge I_CLOCK) begin
        if (w_push) begin
            r_op[r_wr]    <= I_Opcode;
            r_sen[r_wr]   <= w_sen;
            r_sidx[r_wr]  <= w_sidx;
            r_sdata[r_wr] <= w_sdata;
            r_ven[r_wr]   <= w_ven;
            r_vidx[r_wr]  <= w_vidx;
            r_vmask[r_wr] <= w_vmask;
            r_vdata[r_wr] <= w_vdata;
        end
    end

    assign O_Ready              = w_space & ~I_RESET;
    assign O_Count              = I_RESET ? '0 : r_count;
    assign O_FetchStall         = r_fetch_stall_p1 & ~I_RESET;
    assign O_DepStall           = r_dep_stall_p1 & ~I_RESET;
    assign O_Opcode             = w_pop ? r_op[r_rd]    : '0;
    assign O_WriteBackEnable    = w_pop & r_sen[r_rd];
    assign O_WriteBackRegIdx    = w_pop ? r_sidx[r_rd]  : '0;
    assign O_WriteBackData      = w_pop ? r_sdata[r_rd] : '0;
    assign O_WriteBackEnableV   = w_pop & r_ven[r_rd];
    assign O_WriteBackRegIdxV   = w_pop ? r_vidx[r_rd]  : '0;
    assign O_WriteBackLaneMaskV = w_pop ? r_vmask[r_rd] : '0;
    assign O_WriteBackDataV     = w_pop ? r_vdata[r_rd] : '0;
endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: queue-level reference model compared every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_writeback_unit;
    localparam int DEPTH = 4;
    localparam logic [7:0] ADD_D = 8'h01, ADDI_D = 8'h02, AND_D = 8'h03, ANDI_D = 8'h04,
                           MOV = 8'h05, MOVI_D = 8'h06, JSR = 8'h07, JSRR = 8'h08,
                           LDW = 8'h09, VADD = 8'h10, VMOV = 8'h11,
                           VCOMPMOV = 8'h12, VCOMPMOVI = 8'h13;

    logic        clk = 1'b0, rst, lock, valid, fstall, dstall, rfready;
    logic [7:0]  op;
    logic [3:0]  sidx;
    logic [5:0]  vidx;
    logic [1:0]  lane;
    logic [15:0] alu, mem;
    logic [63:0] aluv;
    logic        ready, we, wev, ofs, ods;
    logic [3:0]  widx, wmask;
    logic [5:0]  widxv;
    logic [15:0] wdata;
    logic [63:0] wdatav;
    logic [7:0]  oop;
    logic [2:0]  cnt;

    int checks = 0, failures = 0;

    writeback_unit dut (
        .I_CLOCK(clk), .I_RESET(rst), .I_LOCK(lock), .I_Valid(valid), .O_Ready(ready),
        .I_Opcode(op), .I_DestRegIdx(sidx), .I_DestRegIdxV(vidx), .I_DestLane(lane),
        .I_ALUOut(alu), .I_MemOut(mem), .I_ALUOutV(aluv),
        .I_FetchStall(fstall), .I_DepStall(dstall), .I_RFReady(rfready),
        .O_WriteBackEnable(we), .O_WriteBackRegIdx(widx), .O_WriteBackData(wdata),
        .O_WriteBackEnableV(wev), .O_WriteBackRegIdxV(widxv), .O_WriteBackLaneMaskV(wmask),
        .O_WriteBackDataV(wdatav), .O_Opcode(oop),
        .O_FetchStall(ofs), .O_DepStall(ods), .O_Count(cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [7:0]  op;
        logic        sen;
        logic [3:0]  sidx;
        logic [15:0] sdata;
        logic        ven;
        logic [5:0]  vidx;
        logic [3:0]  mask;
        logic [63:0] vdata;
    } ent_t;

    ent_t mq[$];
    bit   mfs = 0, mds = 0, armed = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic ent_t mk(input logic [7:0] o, input logic [3:0] s, input logic [5:0] v,
                                input logic [1:0] l, input logic [15:0] a, input logic [15:0] m,
                                input logic [63:0] av);
        ent_t e = '0;
        e.op = o;
        if (o inside {ADD_D, ADDI_D, AND_D, ANDI_D, MOV, MOVI_D, JSR, JSRR}) begin
            e.sen = 1; e.sidx = s; e.sdata = a;
        end else if (o == LDW) begin
            e.sen = 1; e.sidx = s; e.sdata = m;
        end else if (o inside {VADD, VMOV}) begin
            e.ven = 1; e.vidx = v; e.mask = 4'hF; e.vdata = av;
        end else if (o inside {VCOMPMOV, VCOMPMOVI}) begin
            e.sen = 1; e.sidx = s; e.sdata = a;
            e.ven = 1; e.vidx = v; e.mask = 4'b0001 << l; e.vdata = {4{a}};
        end
        return e;
    endfunction

    // Reference model: inputs are stable across the negedge, so compare then advance
    always @(negedge clk) begin
        ent_t h;
        bit   pop, acc;
        if (rst) armed = 1;
        if (armed) begin
            pop = !rst && lock && rfready && mq.size() > 0;
            h   = pop ? mq[0] : '0;
            check("m_ready", ready, (!rst && mq.size() < DEPTH));
            check("m_count", cnt, rst ? 0 : mq.size());
            check("m_we", we, h.sen);
            check("m_widx", widx, h.sidx);
            check("m_wdata", wdata, h.sdata);
            check("m_wev", wev, h.ven);
            check("m_widxv", widxv, h.vidx);
            check("m_wmask", wmask, h.mask);
            check("m_wdatav", wdatav, h.vdata);
            check("m_opcode", oop, h.op);
            check("m_fstall", ofs, rst ? 1'b0 : mfs);
            check("m_dstall", ods, rst ? 1'b0 : mds);
            if (rst) begin
                mq.delete(); mfs = 0; mds = 0;
            end else begin
                acc = lock && valid && mq.size() < DEPTH && !fstall && !dstall;
                if (pop) void'(mq.pop_front());
                if (acc) begin
                    h = mk(op, sidx, vidx, lane, alu, mem, aluv);
                    if (h.sen || h.ven) mq.push_back(h);
                end
                mfs = fstall; mds = dstall;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [7:0] o, input logic [3:0] s, input logic [5:0] v,
                         input logic [1:0] l, input logic [15:0] a, input logic [15:0] m,
                         input logic [63:0] av);
        valid = 1; op = o; sidx = s; vidx = v; lane = l; alu = a; mem = m; aluv = av;
    endtask

    task automatic idle();
        valid = 0; op = 8'h00;
    endtask

    function automatic logic [63:0] pat(input int i);
        logic [15:0] b = 16'hA000 + 16'(i);
        return {b, ~b, b, ~b};
    endfunction

    logic [3:0]  exp_idx  [4] = '{4'd1, 4'd2, 4'd2, 4'd0};
    logic [15:0] exp_dat  [4] = '{16'h0101, 16'h0202, 16'h0303, 16'h0000};

    initial begin
        rst = 1; lock = 1; valid = 0; fstall = 0; dstall = 0; rfready = 1;
        op = 0; sidx = 0; vidx = 0; lane = 0; alu = 0; mem = 0; aluv = 0;
        step(); step();
        rst = 0;
        #2;
        check("rst_ready", ready, 1);
        check("rst_count", cnt, 0);
        check("rst_we", we, 0);

        // Scalar ADDI_D writes back one cycle after acceptance
        issue(ADDI_D, 4'd3, 6'd0, 2'd0, 16'h1234, 16'h0, 64'h0);
        step(); idle(); #2;
        check("addi_we", we, 1);
        check("addi_idx", widx, 3);
        check("addi_data", wdata, 16'h1234);
        check("addi_wev", wev, 0);
        step();

        // Component move: one-hot lane mask, value replicated, scalar write too
        issue(VCOMPMOVI, 4'd7, 6'd5, 2'd2, 16'h00AB, 16'h0, 64'h0);
        step(); idle(); #2;
        check("comp_wev", wev, 1);
        check("comp_idxv", widxv, 5);
        check("comp_mask", wmask, 4'b0100);
        check("comp_datav", wdatav, 64'h00AB_00AB_00AB_00AB);
        check("comp_we", we, 1);
        check("comp_idx", widx, 7);
        step();

        // Fill with RFReady low; later write to reg 2 must win
        rfready = 0;
        issue(ADD_D, 4'd1, 6'd0, 2'd0, 16'h0101, 16'h0, 64'h0); step();
        issue(LDW,   4'd2, 6'd0, 2'd0, 16'hDEAD, 16'h0202, 64'h0); step();
        issue(ANDI_D, 4'd2, 6'd0, 2'd0, 16'h0303, 16'h0, 64'h0); step();
        issue(VMOV,  4'd0, 6'd9, 2'd0, 16'h0, 16'h0, 64'h1111_2222_3333_4444); step();
        issue(JSR,   4'd6, 6'd0, 2'd0, 16'h0606, 16'h0, 64'h0); #2;
        check("full_ready", ready, 0);
        check("full_count", cnt, 4);
        step(); #2;
        check("held_count", cnt, 4);
        idle(); rfready = 1;
        for (int j = 0; j < 4; j++) begin
            #1;
            check("drain_we", we, j < 3);
            check("drain_idx", widx, exp_idx[j]);
            check("drain_data", wdata, exp_dat[j]);
            step();
        end
        #2;
        check("drain_wev_last", wev, 0);
        check("drain_empty", cnt, 0);

        // Dependency stall blocks LDW and surfaces one cycle later
        issue(LDW, 4'd5, 6'd0, 2'd0, 16'h0, 16'h5555, 64'h0); dstall = 1;
        step(); idle(); dstall = 0; #2;
        check("dep_count", cnt, 0);
        check("dep_out", ods, 1);
        check("dep_we", we, 0);
        step(); #2;
        check("dep_clear", ods, 0);

        // Non-writing opcode is accepted but never enqueued
        issue(8'hFF, 4'd1, 6'd1, 2'd0, 16'h7777, 16'h0, 64'h0);
        step(); idle(); #2;
        check("nop_count", cnt, 0);
        check("nop_we", we, 0);

        // I_LOCK low freezes the queue; stall flags still propagate
        rfready = 0;
        issue(ADD_D, 4'd4, 6'd0, 2'd0, 16'h4444, 16'h0, 64'h0); step();
        issue(VADD, 4'd0, 6'd3, 2'd0, 16'h0, 16'h0, 64'h0123_4567_89AB_CDEF); step();
        lock = 0; rfready = 1; fstall = 1;
        issue(MOV, 4'd8, 6'd0, 2'd0, 16'h8888, 16'h0, 64'h0); #2;
        check("lock_we", we, 0);
        step(); #2;
        check("lock_count", cnt, 2);
        check("lock_fstall", ofs, 1);
        lock = 1; fstall = 0; idle(); #1;
        check("lock_we1", we, 1);
        check("lock_data1", wdata, 16'h4444);
        step(); #2;
        check("lock_wev2", wev, 1);
        check("lock_datav2", wdatav, 64'h0123_4567_89AB_CDEF);
        step();

        // Reset with three queued entries and a valid instruction present
        rfready = 0;
        for (int i = 0; i < 3; i++) begin
            issue(MOVI_D, 4'(i + 10), 6'd0, 2'd0, 16'(16'hC000 + i), 16'h0, 64'h0);
            step();
        end
        rst = 1; issue(JSRR, 4'd15, 6'd0, 2'd0, 16'hFFFF, 16'h0, 64'h0);
        step(); rst = 0; idle(); rfready = 1; #2;
        check("rst2_count", cnt, 0);
        check("rst2_ready", ready, 1);
        check("rst2_we", we, 0);
        check("rst2_wev", wev, 0);
        step(); #2;
        check("rst2_we_after", we, 0);

        // Streaming push/pop across pointer wrap
        issue(VADD, 4'd0, 6'd0, 2'd0, 16'h0, 16'h0, pat(0));
        step();
        for (int i = 0; i < 2 * DEPTH + 1; i++) begin
            if (i < 2 * DEPTH) issue(VADD, 4'd0, 6'(i + 1), 2'd0, 16'h0, 16'h0, pat(i + 1));
            else idle();
            #2;
            check("wrap_datav", wdatav, pat(i));
            check("wrap_cnt_le1", cnt <= 1, 1);
            step();
        end
        #2;
        check("wrap_end_count", cnt, 0);
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
